lc3_microsequencer: RTL and testbench

Next-microstate generator for the LC-3 microcoded control unit. It takes the current microinstruction's sequencing fields (IRD, COND, J) from the control store, combines them with datapath status (IR, NZP, memory ready, privilege, ACV, interrupt), and drives the 6-bit next-state address the control store registers on each rising clock edge. It also owns the BEN register, the pending-interrupt latch, a fetch counter and an optional memory-wait watchdog.

---
 rtl/lc3_microsequencer.sv | 122 ++++++++++++
 tb/tb_lc3_microsequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: next-microstate address, BEN, interrupt latch, fetch counter.
// Optional memory-wait watchdog enabled by defining LC3_USEQ_WATCHDOG_EN.
module lc3_microsequencer #(
    parameter logic [5:0] RESET_STATE = 6'd18,
    parameter int         MAX_WAIT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IRD,
    input  logic [2:0]  COND,
    input  logic [5:0]  J,
    input  logic        LD_BEN,
    input  logic [6:0]  IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        R,
    input  logic        PSR15,
    input  logic        ACV,
    input  logic        int_req,
    output logic [5:0]  Addr_next_state,
    output logic        int_ack,
    output logic [5:0]  cur_state,
    output logic [15:0] fetch_count,
    output logic        mem_timeout
);

    logic        ben_q, ben_d;
    logic        int_pending_q, int_pending_d;
    logic [5:0]  cur_state_q;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [5:0]  addr;
    logic        ack;

    // IR port holds IR[15:9]: [6:3] opcode, [2] IR11, [1] IR10, [0] IR9
    always_comb begin
        addr = J;
        ack  = 1'b0;
        if (!rst_n) begin
            addr = RESET_STATE;
        end else if (IRD) begin
            addr = {2'b00, IR[6:3]};
        end else begin
            case (COND)
                3'b001: addr[1] = J[1] | R;
                3'b010: addr[2] = J[2] | ben_q;
                3'b011: addr[0] = J[0] | IR[2];
                3'b100: addr[3] = J[3] | PSR15;
                3'b101: begin
                    addr[4] = J[4] | int_pending_q;
                    ack     = int_pending_q;
                end
                3'b110: addr[5] = J[5] | ACV;
                default: addr = J;
            endcase
        end
    end

    always_comb begin
        ben_d = ben_q;
        if (LD_BEN)
            ben_d = (IR[2] & N) | (IR[1] & Z) | (IR[0] & P);
        // A new request in the same cycle as the acknowledge keeps the latch set
        int_pending_d = int_pending_q;
        if (int_req)
            int_pending_d = 1'b1;
        else if (ack)
            int_pending_d = 1'b0;
        fetch_count_d = fetch_count_q;
        if (addr == RESET_STATE)
            fetch_count_d = fetch_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ben_q         <= 1'b0;
            int_pending_q <= 1'b0;
            cur_state_q   <= RESET_STATE;
            fetch_count_q <= 16'd0;
        end else begin
            ben_q         <= ben_d;
            int_pending_q <= int_pending_d;
            cur_state_q   <= addr;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef LC3_USEQ_WATCHDOG_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    logic [WW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        wait_d = '0;
        if (!IRD && (COND == 3'b001) && !R)
            wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + WW'(1);
        timeout_d = timeout_q | (wait_d == WAIT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;
`else
    assign mem_timeout = 1'b0;
`endif

    assign Addr_next_state = addr;
    assign int_ack         = ack;
    assign cur_state       = cur_state_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Self-checking bench for lc3_microsequencer: per-cycle reference model plus directed literal checks.
module tb_lc3_microsequencer;

    localparam logic [5:0] RS = 6'd18;
    localparam int         MW = 4;

    logic        clk = 1'b0;
    logic        rst_n, IRD, LD_BEN, N, Z, P, R, PSR15, ACV, int_req;
    logic [2:0]  COND;
    logic [5:0]  J;
    logic [6:0]  IR;
    logic [5:0]  Addr_next_state, cur_state;
    logic        int_ack, mem_timeout;
    logic [15:0] fetch_count;

    int errs = 0;
    int checks = 0;

    lc3_microsequencer #(.RESET_STATE(RS), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .IRD(IRD), .COND(COND), .J(J), .LD_BEN(LD_BEN),
        .IR(IR), .N(N), .Z(Z), .P(P), .R(R), .PSR15(PSR15), .ACV(ACV),
        .int_req(int_req), .Addr_next_state(Addr_next_state), .int_ack(int_ack),
        .cur_state(cur_state), .fetch_count(fetch_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic        m_ben, m_pend, m_tmo, started;
    logic [5:0]  m_cur;
    logic [15:0] m_fc;
    int          m_wait;

    function automatic logic [5:0] exp_addr();
        logic [5:0] a;
        if (!rst_n) return RS;
        if (IRD) return 6'(IR[6:3]);
        a = J;
        case (COND)
            3'd1: a = a | (6'(R) << 1);
            3'd2: a = a | (6'(m_ben) << 2);
            3'd3: a = a | 6'(IR[2]);
            3'd4: a = a | (6'(PSR15) << 3);
            3'd5: a = a | (6'(m_pend) << 4);
            3'd6: a = a | (6'(ACV) << 5);
            default: a = J;
        endcase
        return a;
    endfunction

    function automatic logic exp_ack();
        return rst_n && !IRD && COND == 3'd5 && m_pend;
    endfunction

    initial started = 1'b0;

    always @(posedge clk) begin
        logic [5:0] a;
        logic       k;
        a = exp_addr();
        k = exp_ack();
        if (!rst_n) begin
            m_ben = 0; m_pend = 0; m_cur = RS; m_fc = 0; m_wait = 0; m_tmo = 0;
            started = 1'b1;
        end else begin
            m_cur = a;
            if (a == RS) m_fc = m_fc + 16'd1;
            if (LD_BEN) m_ben = (IR[2] && N) || (IR[1] && Z) || (IR[0] && P);
            if (int_req) m_pend = 1;
            else if (k) m_pend = 0;
            if (!IRD && COND == 3'd1 && !R) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            else m_wait = 0;
            if (m_wait >= MW) m_tmo = 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic exp_tmo;
    always @(negedge clk) begin
        if (started) begin
`ifdef LC3_USEQ_WATCHDOG_EN
            exp_tmo = m_tmo;
`else
            exp_tmo = 1'b0;
`endif
            chk("model_addr", 16'(Addr_next_state), 16'(exp_addr()));
            chk("model_ack", 16'(int_ack), 16'(exp_ack()));
            chk("model_cur", 16'(cur_state), 16'(m_cur));
            chk("model_fetch", fetch_count, m_fc);
            chk("model_timeout", 16'(mem_timeout), 16'(exp_tmo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] j);
        IRD = 0; COND = 3'd0; J = j; LD_BEN = 0; int_req = 0; R = 0; ACV = 0; PSR15 = 0;
    endtask

    initial begin
        rst_n = 0; IR = '0; N = 0; Z = 0; P = 0;
        idle(6'd0);
        step(); step();
        chk("rst_addr", 16'(Addr_next_state), 16'd18);
        chk("rst_cur", 16'(cur_state), 16'd18);
        chk("rst_fetch", fetch_count, 16'd0);
        chk("rst_ack", 16'(int_ack), 16'd0);
        rst_n = 1; idle(RS);
        step();
        chk("first_fetch", fetch_count, 16'd1);

        // Decode dispatch
        IRD = 1; COND = 3'd2; IR = 7'b0001_000; #1;
        chk("decode_1", 16'(Addr_next_state), 16'd1);
        step();
        IR = 7'b1111_000; #1;
        chk("decode_15", 16'(Addr_next_state), 16'd15);
        step();
        chk("decode_cur", 16'(cur_state), 16'd15);

        // BEN branch
        idle(6'd0); IR = 7'b0000_010; Z = 1; LD_BEN = 1;
        step();
        LD_BEN = 0; COND = 3'd2; J = 6'd22; #1;
        chk("ben_j22", 16'(Addr_next_state), 16'd22);
        J = 6'd18; #1;
        chk("ben_j18", 16'(Addr_next_state), 16'd22);
        step();
        Z = 0; LD_BEN = 1; COND = 3'd0; J = 6'd0;
        step();
        LD_BEN = 0; COND = 3'd2; J = 6'd18; #1;
        chk("ben_clear", 16'(Addr_next_state), 16'd18);
        step();

        // IR11, PSR15 and ACV conditions
        COND = 3'd3; J = 6'd0; IR = 7'b0000_100; #1;
        chk("cond_ir11", 16'(Addr_next_state), 16'd1);
        COND = 3'd4; PSR15 = 1; #1;
        chk("cond_psr", 16'(Addr_next_state), 16'd8);
        COND = 3'd6; J = 6'd18; ACV = 1; #1;
        chk("cond_acv", 16'(Addr_next_state), 16'd50);
        step();

        // Memory wait
        idle(6'd33); COND = 3'd1;
        for (int i = 0; i < MW; i++) begin
            #1 chk("mem_wait", 16'(Addr_next_state), 16'd33);
            step();
        end
`ifdef LC3_USEQ_WATCHDOG_EN
        chk("wd_set", 16'(mem_timeout), 16'd1);
`else
        chk("wd_off", 16'(mem_timeout), 16'd0);
`endif
        R = 1; #1;
        chk("mem_ready", 16'(Addr_next_state), 16'd35);
        step();
`ifdef LC3_USEQ_WATCHDOG_EN
        chk("wd_sticky", 16'(mem_timeout), 16'd1);
`else
        chk("wd_off2", 16'(mem_timeout), 16'd0);
`endif

        // Interrupt
        idle(6'd0); int_req = 1;
        step();
        int_req = 0; COND = 3'd5; J = 6'd2; #1;
        chk("int_branch", 16'(Addr_next_state), 16'd18);
        chk("int_ack", 16'(int_ack), 16'd1);
        step();
        chk("int_ack_gone", 16'(int_ack), 16'd0);
        chk("int_cleared", 16'(Addr_next_state), 16'd2);
        COND = 3'd0; int_req = 1;
        step();
        COND = 3'd5; int_req = 1; #1;
        chk("int_ack_setwins", 16'(int_ack), 16'd1);
        step();
        int_req = 0; #1;
        chk("int_still_pend", 16'(int_ack), 16'd1);
        step();
        chk("int_done", 16'(int_ack), 16'd0);

        // Mid-operation reset
        idle(6'd5); IRD = 1; int_req = 1; LD_BEN = 1; rst_n = 0; #1;
        chk("rst_force", 16'(Addr_next_state), 16'd18);
        chk("rst_force_ack", 16'(int_ack), 16'd0);
        step();
        chk("rst_mid_fetch", fetch_count, 16'd0);
        chk("rst_mid_cur", 16'(cur_state), 16'd18);
        rst_n = 1; idle(RS);

        // Fetch counter wrap
        repeat (65535) step();
        chk("fetch_ffff", fetch_count, 16'hFFFF);
        step();
        chk("fetch_wrap", fetch_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
